uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit buffer directly upstream of the UART transmitter. Host/peripheral-bus writes bytes in; the transmitter pulls them out.
- Transmitter's txStart is driven from ~empty.
- Transmitter's txDoneTick, its one-cycle read strobe issued in idle, drives rd.
- rdData feeds transmitter din. The popped word must stay stable for the whole frame, because the transmitter samples din throughout its start state.

Parameters:
dataBits, `dataBits (8), width of each stored word
addrBits, 4, log2 of depth; depth = 2**addrBits (16 entries)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr  input  1  write strobe, one word per cycle when high
wrData  input  dataBits  word to enqueue
rd  input  1  read strobe (from transmitter txDoneTick)
rdData  output  dataBits  last popped word, registered, held until next accepted read
empty  output  1  no stored words
full  output  1  2**addrBits words stored
count  output  addrBits+1  number of stored words
ovf  output  1  sticky: write attempted while full
udf  output  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: wrPtr=0, rdPtr=0, count=0, rdData=0, empty=1, full=0, ovf=0, udf=0. Storage contents are don't-care.
- Reset mid-operation (including mid-frame of the transmitter) discards all contents immediately. Outputs take their reset values asynchronously.
- Pointers are addrBits wide and wrap naturally from 2**addrBits-1 to 0.
- empty and full are registered, derived from count: empty = (count==0), full = (count==2**addrBits).
- Write accepted when wr && (!full || rd_accepted):
  - mem[wrPtr] <= wrData
  - wrPtr increments
- Read accepted when rd && !empty:
  - rdData <= mem[rdPtr] on that same edge
  - rdPtr increments
- Read latency:
  - rdData shows the popped word from the cycle after rd.
  - rdData is unchanged by writes and by rejected reads.
  - It holds until the next accepted read.
- Simultaneous wr and rd:
  - Not empty: both accepted, count unchanged.
  - Full: both accepted, count stays at max, no ovf.
  - Empty: write accepted, read rejected, udf set, count becomes 1. No bypass into rdData.
- count: +1 on write only, -1 on read only, otherwise unchanged. It never exceeds 2**addrBits and never underflows.
- Rejected write (wr && full && !rd) sets ovf. Rejected read sets udf. Both flags stay set until reset.
- Transmitter interaction:
  - rd is a single-cycle pulse per frame.
  - Back-to-back rd pulses on consecutive cycles are legal; each pops one word.

Decomposition:
- defines.v holds the defaults:
  - `dataBits (existing)
  - `txFifoAddrBits (new, 4) for addrBits
- One sub-module: uart_fifo_mem.
  - 2**addrBits x dataBits register array.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port (raddr -> rdata).
- uart_tx_fifo holds the pointers, count, flags and the rdData register.
- No other sub-modules.

Test Plan:
1. Reset then idle 5 cycles -> empty=1, full=0, count=0, rdData=0x00, ovf=udf=0.
2. Write 0xA5, 0x3C, then rd pulse:
   - Cycle after rd: rdData=0xA5, count=1.
   - Second rd: rdData=0x3C, empty=1.
   - rdData then holds 0x3C with no rd activity.
3. Write 16 words 0x00..0x0F -> full=1, count=16. 17th write of 0xFF -> ovf=1, count stays 16. Drain 16 reads -> 0x00..0x0F in order, 0xFF never appears.
4. Full FIFO, wr=1 (0x77) and rd=1 on the same cycle -> rdData=0x00, count=16, ovf=0. After draining, 0x77 is the last word out. Pointer wrap is exercised.
5. Empty FIFO, wr=1 (0x5A) and rd=1 on the same cycle -> udf=1, count=1, rdData unchanged. Next rd -> rdData=0x5A.
6. Connect to uartTrans with sTick every 16 clk, load 0x55, 0x0F:
   - tx shows two frames LSB first, start bit 0, stop bit 1.
   - The second frame begins only after the first frame's stop bit.
   - Assert reset mid-second-frame -> count=0, empty=1 immediately.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared defaults and helpers for the UART transmit FIFO
//
// Purpose: default word width and depth for the transmit buffer, plus a helper
// that gives the occupancy value meaning "full" for a given address width.
package uart_tx_fifo_pkg;

    // Default width of each stored word (the UART character size).
    localparam int DATA_BITS = 8;

    // Default log2 of the FIFO depth (16 entries).
    localparam int TX_FIFO_ADDR_BITS = 4;

    // Occupancy value of a completely full FIFO: 2**addr_bits.
    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register-array storage for the UART transmit FIFO
//
// Purpose: 2**addrBits x dataBits storage with one synchronous write port and
// one combinational read port. Contents are not reset.
// Ports:
//   clk    - write clock
//   we     - write enable, stores wdata at waddr on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - contents at raddr (combinational)
module uart_fifo_mem #(
    parameter int dataBits = 8,
    parameter int addrBits = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [addrBits-1:0] waddr,
    input  logic [dataBits-1:0] wdata,
    input  logic [addrBits-1:0] raddr,
    output logic [dataBits-1:0] rdata
);

    logic [dataBits-1:0] mem_q [2**addrBits];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a write and a read at the same
    // address on one edge returns the old word (needed when full).
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit buffer feeding the UART transmitter
//
// Purpose: bus writes bytes in, the transmitter pops them with its one-cycle
// done tick. The popped word is registered and held until the next accepted
// read so the transmitter can sample it throughout a frame.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   wr     - write strobe, one word per cycle
//   wrData - word to enqueue
//   rd     - read strobe (transmitter done tick)
//   rdData - last popped word, registered
//   empty  - no stored words (registered)
//   full   - 2**addrBits words stored (registered)
//   count  - number of stored words
//   ovf    - sticky: write attempted while full without a read
//   udf    - sticky: read attempted while empty
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int dataBits = DATA_BITS,
    parameter int addrBits = TX_FIFO_ADDR_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [dataBits-1:0] wrData,
    input  logic                rd,
    output logic [dataBits-1:0] rdData,
    output logic                empty,
    output logic                full,
    output logic [addrBits:0]   count,
    output logic                ovf,
    output logic                udf
);

    localparam logic [addrBits:0] DEPTH = (addrBits+1)'(fifo_depth(addrBits));

    logic [addrBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [addrBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [addrBits:0]   count_q, count_d;
    logic [dataBits-1:0] rd_data_q, rd_data_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic                rd_acc;
    logic                wr_acc;
    logic [dataBits-1:0] mem_rdata;

    uart_fifo_mem #(
        .dataBits (dataBits),
        .addrBits (addrBits)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wrData),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_acc = rd && !empty_q;
        // A read on the same edge frees the slot, so a full FIFO still
        // accepts a write alongside an accepted read.
        wr_acc = wr && (!full_q || rd_acc);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        count_d   = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_rdata;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH);
        ovf_d   = ovf_q || (wr && full_q && !rd);
        udf_d   = udf_q || (rd && empty_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign rdData = rd_data_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
